// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the iterative RV64 M-extension sequencer.
package mdu_seq_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  // Most negative values at full and word width (word value already sign-extended).
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  typedef enum logic [2:0] {
    OpMul  = 3'd0,
    OpDiv  = 3'd1,
    OpDivu = 3'd2,
    OpRem  = 3'd3,
    OpRemu = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } mdu_state_t;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response handshake between the EX stage and the multiply/divide sequencer.
interface mdu_seq_if;
  import mdu_seq_pkg::*;

  logic            req_valid;
  logic            req_ready;
  mdu_op_t         req_op;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_word, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_word, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/mdu_iter.sv
// One step of the shared datapath: shift-add for multiply, restoring step for divide.
module mdu_iter
  import mdu_seq_pkg::*;
(
  input  logic            mul,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic [XLEN-1:0] b_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted = {hi, lo[XLEN-1]};
    trial   = shifted - {1'b0, b};
    if (mul) begin
      // hi: accumulator, lo: multiplier (consumed LSB first), b: multiplicand
      hi_nxt = lo[0] ? hi + b : hi;
      lo_nxt = {1'b0, lo[XLEN-1:1]};
      b_nxt  = {b[XLEN-2:0], 1'b0};
    end else begin
      // hi: partial remainder, lo: dividend shifting out / quotient shifting in
      hi_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~trial[XLEN]};
      b_nxt  = b;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: one bit per cycle, valid/ready result handshake.
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  mdu_seq_if.slave   bus,
  output logic       busy
);

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  mdu_op_t          op_q;
  logic             word_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic             resp_valid_q;
  logic [XLEN-1:0]  result_q;

  logic [XLEN-1:0]  hi_nxt, lo_nxt, b_nxt;
  logic             is_signed, is_mul, is_rem;
  logic [XLEN-1:0]  ext_a, ext_b, mag_a, mag_b;
  logic             neg_a, neg_b, dbz, ovf, special;
  logic [XLEN-1:0]  special_res, fix_res;

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign busy            = (state_q != StIdle);

  mdu_iter u_iter (
    .mul    (op_q == OpMul),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt),
    .b_nxt  (b_nxt)
  );

  // Operand preparation and divide special cases, evaluated on the incoming request.
  always_comb begin
    is_signed = (bus.req_op == OpDiv) || (bus.req_op == OpRem);
    is_mul    = (bus.req_op == OpMul);
    is_rem    = (bus.req_op == OpRem) || (bus.req_op == OpRemu);
    ext_a     = bus.req_a;
    ext_b     = bus.req_b;
    if (bus.req_word) begin
      ext_a = is_signed ? sext_w(bus.req_a) : {{(XLEN-32){1'b0}}, bus.req_a[31:0]};
      ext_b = is_signed ? sext_w(bus.req_b) : {{(XLEN-32){1'b0}}, bus.req_b[31:0]};
    end
    neg_a   = is_signed && ext_a[XLEN-1];
    neg_b   = is_signed && ext_b[XLEN-1];
    mag_a   = neg_a ? -ext_a : ext_a;
    mag_b   = neg_b ? -ext_b : ext_b;
    dbz     = (ext_b == '0);
    ovf     = is_signed && (ext_b == '1) && (ext_a == (bus.req_word ? MIN_W : MIN_D));
    special = !is_mul && (dbz || ovf);
    // Overflow quotient equals the (extended) dividend, as does the div-by-zero remainder.
    if (is_rem) special_res = dbz ? ext_a : '0;
    else        special_res = dbz ? '1 : ext_a;
    if (bus.req_word) special_res = sext_w(special_res);
  end

  always_comb begin
    fix_res = hi_q;
    case (op_q)
      OpDiv, OpDivu: fix_res = quo_neg_q ? -lo_q : lo_q;
      OpRem, OpRemu: fix_res = rem_neg_q ? -hi_q : hi_q;
      default:       fix_res = hi_q;
    endcase
    if (word_q) fix_res = sext_w(fix_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= OpMul;
      word_q       <= 1'b0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else if (flush) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            word_q    <= bus.req_word;
            quo_neg_q <= neg_a ^ neg_b;
            rem_neg_q <= neg_a;
            hi_q      <= '0;
            cnt_q     <= bus.req_word ? CNT_W'(32) : CNT_W'(XLEN);
            if (is_mul) begin
              lo_q <= ext_b;
              b_q  <= ext_a;
            end else begin
              // Word dividends sit in the upper half so the MSB-first shift sees them.
              lo_q <= bus.req_word ? {mag_a[31:0], 32'b0} : mag_a;
              b_q  <= mag_b;
            end
            if (special) begin
              result_q     <= special_res;
              resp_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          b_q   <= b_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= StFixup;
        end
        StFixup: begin
          result_q     <= fix_res;
          resp_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: results, latency, special cases, flush, stall and async reset.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   n_checks;
  int   n_pass;

  mdu_seq_if bus ();

  mdu_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start_op(input mdu_op_t op, input logic word, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_word  = word;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat, output int busy_drop);
    lat       = 0;
    busy_drop = 0;
    while (!bus.resp_valid && lat < 200) begin
      if (!busy) busy_drop++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take_resp(input string tag);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check({tag, " idle valid"}, {63'b0, bus.resp_valid}, 64'd0);
    check({tag, " idle ready"}, {63'b0, bus.req_ready}, 64'd1);
  endtask

  task automatic run(input string tag, input mdu_op_t op, input logic word,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    int drop;
    start_op(op, word, a, b);
    wait_resp(lat, drop);
    check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(drop), 64'd0);
    check({tag, " res"}, bus.resp_result, exp);
    take_resp(tag);
  endtask

  initial begin
    int lat;
    int drop;
    int seen;
    logic [63:0] held;
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = OpMul;
    bus.req_word   = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    #22;
    check("rst ready", {63'b0, bus.req_ready}, 64'd1);
    check("rst valid", {63'b0, bus.resp_valid}, 64'd0);
    check("rst busy", {63'b0, busy}, 64'd0);
    check("rst result", bus.resp_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul", OpMul, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run("div", OpDiv, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run("rem", OpRem, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("divu", OpDivu, 1'b0, 64'd20, 64'd3, 64'd6, 65);
    run("mulw", OpMul, 1'b1, 64'h1234_5678_4000_0000, 64'd3, 64'hFFFF_FFFF_C000_0000, 33);
    run("divw", OpDiv, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run("remw", OpRem, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("divw ovf", OpDiv, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 0);
    run("remw ovf", OpRem, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'd0, 0);
    run("div ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 0);
    run("divu0", OpDivu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("remu0", OpRemu, 1'b0, 64'd5, 64'd0, 64'd5, 0);

    // Flush mid-CALC: the killed op must never respond.
    start_op(OpMul, 1'b0, 64'd9, 64'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush ready", {63'b0, bus.req_ready}, 64'd1);
    check("flush busy", {63'b0, busy}, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (bus.resp_valid) seen++;
    end
    check("flush no resp", 64'(seen), 64'd0);
    run("divu post", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Stall in DONE: output held stable while resp_ready is low.
    start_op(OpDivu, 1'b0, 64'd20, 64'd3);
    wait_resp(lat, drop);
    check("stall lat", 64'(lat), 64'd65);
    held = bus.resp_result;
    check("stall res", held, 64'd6);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (!bus.resp_valid || bus.resp_result !== held) seen++;
    end
    check("stall stable", 64'(seen), 64'd0);
    take_resp("stall");

    // Flush and resp_ready together in DONE: flush wins, no handshake.
    start_op(OpDivu, 1'b0, 64'd5, 64'd0);
    check("fd valid", {63'b0, bus.resp_valid}, 64'd1);
    @(negedge clk);
    flush          = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.resp_ready = 1'b0;
    check("fd flushed", {63'b0, bus.resp_valid}, 64'd0);
    check("fd ready", {63'b0, bus.req_ready}, 64'd1);

    // Asynchronous reset mid-CALC, applied between clock edges.
    start_op(OpMul, 1'b0, 64'd3, 64'd5);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst busy", {63'b0, busy}, 64'd0);
    check("arst ready", {63'b0, bus.req_ready}, 64'd1);
    check("arst valid", {63'b0, bus.resp_valid}, 64'd0);
    check("arst result", bus.resp_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post rst", OpMul, 1'b0, 64'd3, 64'd5, 64'd15, 65);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
